// File: rtl/branch_resolver.sv
// Control-flow resolver: accepts BRANCH/JAL/JALR/AUIPC, waits for operands, returns npc with a get_npc pulse.
// Optional: define BR_MISALIGN_CHECK_EN to add the misalign output and self-loop on misaligned targets.
module branch_resolver #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ILEN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      fun3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] opc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            ops_ready,
  output logic            busy,
  output logic [XLEN-1:0] npc,
  output logic            get_npc,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
`ifdef BR_MISALIGN_CHECK_EN
  output logic            misalign,
`endif
  output logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE} state_t;

  state_t          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] imm_q, imm_d, opc_q, opc_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] npc_q, npc_d;

  logic            is_ctrl, is_branch_like, resolve, taken, mis;
  logic [XLEN-1:0] seq_pc, tgt_pc, jalr_sum, raw_npc, res_npc, link;

  assign is_ctrl = instr_valid && (opcode == OP_BRANCH || opcode == OP_JAL ||
                                   opcode == OP_JALR   || opcode == OP_AUIPC);
  assign is_branch_like = (opcode == OP_BRANCH) || (opcode == OP_JALR);
  assign resolve = (state_q == RESOLVE);

  assign seq_pc   = opc_q + XLEN'(ILEN_BYTES);
  assign tgt_pc   = opc_q + imm_q;
  assign jalr_sum = rs1_q + imm_q;

  always_comb begin
    taken = 1'b0;
    case (f3_q)
      3'b000:  taken = (rs1_q == rs2_q);
      3'b001:  taken = (rs1_q != rs2_q);
      3'b100:  taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  taken = (rs1_q <  rs2_q);
      3'b111:  taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    raw_npc = seq_pc;
    link    = seq_pc;
    case (op_q)
      OP_BRANCH: raw_npc = taken ? tgt_pc : seq_pc;
      OP_JAL:    raw_npc = tgt_pc;
      OP_JALR:   raw_npc = {jalr_sum[XLEN-1:1], 1'b0};
      OP_AUIPC:  link    = tgt_pc;
      default:   raw_npc = seq_pc;
    endcase
  end

`ifdef BR_MISALIGN_CHECK_EN
  assign mis      = resolve && (raw_npc[1:0] != 2'b00);
  assign misalign = mis;
`else
  assign mis      = 1'b0;
`endif

  // A misaligned target parks fetch on the faulting instruction instead.
  assign res_npc  = mis ? opc_q : raw_npc;

  assign busy     = (state_q != IDLE);
  assign get_npc  = resolve;
  assign npc      = resolve ? res_npc : npc_q;
  assign wb_valid = resolve && (op_q != OP_BRANCH) && (rd_q != 5'd0) && !mis;
  assign wb_rd    = wb_valid ? rd_q : '0;
  assign wb_data  = wb_valid ? link : '0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    opc_d   = opc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    npc_d   = npc_q;
    case (state_q)
      IDLE: begin
        if (is_ctrl) begin
          op_d    = opcode;
          f3_d    = fun3;
          rd_d    = rd;
          imm_d   = imm;
          opc_d   = opc;
          state_d = is_branch_like ? WAIT_OPS : RESOLVE;
        end
      end
      WAIT_OPS: begin
        if (ops_ready) begin
          rs1_d   = rs1_val;
          rs2_d   = rs2_val;
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        npc_d   = res_npc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      opc_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      npc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      opc_q   <= opc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      npc_q   <= npc_d;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed vectors push expectations, a negedge monitor checks get_npc pulses.
module tb_branch_resolver;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [4:0]  rd;
  logic [31:0] imm, opc, rs1_val, rs2_val;
  logic        ops_ready;
  logic        busy, get_npc, wb_valid;
  logic [31:0] npc, wb_data;
  logic [4:0]  wb_rd;
`ifdef BR_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  typedef struct packed {
    logic [31:0] npc;
    logic        wbv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  branch_resolver dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .fun3(fun3),
    .rd(rd), .imm(imm), .opc(opc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .ops_ready(ops_ready), .busy(busy), .npc(npc), .get_npc(get_npc),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
`ifdef BR_MISALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per get_npc pulse; pulses with an empty queue are errors.
  always @(negedge clk) begin
    if (!rst) begin
      if (get_npc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_get_npc", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("npc", npc, e.npc);
          chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.wbv});
          if (e.wbv) begin
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_data", wb_data, e.data);
          end
`ifdef BR_MISALIGN_CHECK_EN
          chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
        end
      end else begin
        chk("wb_valid_idle", {31'd0, wb_valid}, 32'd0);
      end
    end
  end

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd_,
                     input logic [31:0] imm_, input logic [31:0] opc_,
                     input logic [31:0] r1, input logic [31:0] r2, input int wait_cyc,
                     input exp_t e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    instr_valid = 1'b1; opcode = op; fun3 = f3; rd = rd_; imm = imm_; opc = opc_;
    rs1_val = '0; rs2_val = '0; ops_ready = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (op == OP_BRANCH || op == OP_JALR) begin
      chk("no_early_get_npc", {31'd0, get_npc}, 32'd0);
      // A control instruction presented while busy must be dropped.
      for (int i = 0; i < wait_cyc; i++) begin
        instr_valid = 1'b1; opcode = OP_JAL; opc = 32'hDEAD0000; imm = 32'h0; rd = 5'd7;
        @(posedge clk); #1;
        chk("busy_wait_ops", {31'd0, busy}, 32'd1);
        chk("no_get_npc_wait", {31'd0, get_npc}, 32'd0);
      end
      instr_valid = 1'b0;
      rs1_val = r1; rs2_val = r2; ops_ready = 1'b1;
      @(posedge clk); #1;
      ops_ready = 1'b0; rs1_val = 32'hA5A5A5A5; rs2_val = 32'h5A5A5A5A;
    end
    chk("get_npc_latency", {31'd0, get_npc}, 32'd1);
    chk("busy_resolve", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("get_npc_one_cycle", {31'd0, get_npc}, 32'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] n, input logic w, input logic [4:0] r,
                              input logic [31:0] d, input logic m);
    exp_t e;
    e.npc = n; e.wbv = w; e.rd = r; e.data = d; e.mis = m;
    return e;
  endfunction

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; fun3 = '0; rd = '0; imm = '0; opc = '0;
    rs1_val = '0; rs2_val = '0; ops_ready = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_get_npc", {31'd0, get_npc}, 32'd0);
    chk("rst_npc", npc, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(OP_JAL,    3'b000, 5'd1, 32'h20,       32'h100, 0, 0, 0, mk(32'h120, 1'b1, 5'd1, 32'h104, 1'b0));
    chk("npc_hold", npc, 32'h120);
    run(OP_BRANCH, 3'b000, 5'd0, 32'hFFFFFFF8, 32'h200, 5, 5, 3, mk(32'h1F8, 1'b0, 5'd0, 32'h0, 1'b0));
    run(OP_BRANCH, 3'b100, 5'd0, 32'h10, 32'h40, 32'hFFFFFFFF, 1, 0, mk(32'h50, 1'b0, 5'd0, 32'h0, 1'b0));
    run(OP_BRANCH, 3'b110, 5'd0, 32'h10, 32'h40, 32'hFFFFFFFF, 1, 1, mk(32'h44, 1'b0, 5'd0, 32'h0, 1'b0));
`ifdef BR_MISALIGN_CHECK_EN
    run(OP_JALR,   3'b000, 5'd2, 32'h0, 32'h300, 32'h1003, 0, 2, mk(32'h300, 1'b0, 5'd0, 32'h0, 1'b1));
`else
    run(OP_JALR,   3'b000, 5'd2, 32'h0, 32'h300, 32'h1003, 0, 2, mk(32'h1002, 1'b1, 5'd2, 32'h304, 1'b0));
`endif
    run(OP_JALR,   3'b000, 5'd5, 32'h11, 32'h380, 32'h1003, 0, 0, mk(32'h1014, 1'b1, 5'd5, 32'h384, 1'b0));
    run(OP_AUIPC,  3'b000, 5'd0, 32'h1000, 32'h10, 0, 0, 0, mk(32'h14, 1'b0, 5'd0, 32'h0, 1'b0));
    run(OP_AUIPC,  3'b000, 5'd9, 32'h1000, 32'h10, 0, 0, 0, mk(32'h14, 1'b1, 5'd9, 32'h1010, 1'b0));
    run(OP_JAL,    3'b000, 5'd3, 32'h8, 32'hFFFFFFFC, 0, 0, 0, mk(32'h4, 1'b1, 5'd3, 32'h0, 1'b0));
    run(OP_BRANCH, 3'b001, 5'd0, 32'h40, 32'h400, 3, 3, 0, mk(32'h404, 1'b0, 5'd0, 32'h0, 1'b0));
    run(OP_BRANCH, 3'b101, 5'd0, 32'h100, 32'h500, 32'h80000000, 0, 0, mk(32'h504, 1'b0, 5'd0, 32'h0, 1'b0));
    run(OP_BRANCH, 3'b111, 5'd0, 32'h100, 32'h500, 32'h80000000, 0, 0, mk(32'h600, 1'b0, 5'd0, 32'h0, 1'b0));
    run(OP_BRANCH, 3'b010, 5'd0, 32'h10, 32'h700, 0, 0, 0, mk(32'h704, 1'b0, 5'd0, 32'h0, 1'b0));
`ifdef BR_MISALIGN_CHECK_EN
    run(OP_JAL,    3'b000, 5'd1, 32'h2, 32'h100, 0, 0, 0, mk(32'h100, 1'b0, 5'd0, 32'h0, 1'b1));
`else
    run(OP_JAL,    3'b000, 5'd1, 32'h2, 32'h100, 0, 0, 0, mk(32'h102, 1'b1, 5'd1, 32'h104, 1'b0));
`endif

    // Non-control opcode must be ignored.
    @(posedge clk); #1;
    instr_valid = 1'b1; opcode = 7'b0110011; opc = 32'h800;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("ignore_non_ctrl", {31'd0, busy}, 32'd0);

    // Reset while waiting for operands abandons the instruction.
    @(posedge clk); #1;
    instr_valid = 1'b1; opcode = OP_BRANCH; fun3 = 3'b000; opc = 32'h900; imm = 32'h40;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_npc", npc, 32'd0);
    chk("rst_mid_get_npc", {31'd0, get_npc}, 32'd0);
    chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_mid_wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ops_ready = 1'b1; rs1_val = 1; rs2_val = 1;
    repeat (4) @(posedge clk);
    #1;
    ops_ready = 1'b0;
    chk("busy_after_rst", {31'd0, busy}, 32'd0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
